bit_serial_scheduler: RTL and testbench
=======================================

# bit_serial_scheduler

Sequences a single shared combination_bit cell (1-bit a XOR b) across two requesters, evaluating WIDTH-bit operand pairs one bit per clock, LSB first. Arbitrates between requesters round-robin, runs one job at a time, and returns the assembled WIDTH-bit result over a valid/ready response port tagged with the requester id. Sits between the requesting datapath blocks and the shared bit cell, so one small timing-closed cell serves wide operands.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_ready  output  1  requester 0 pair accepted this cycle (valid & ready).
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req1_valid  input  1  requester 1 has an operand pair.
- req1_ready  output  1  requester 1 accept strobe.
- req1_a, req1_b  input  WIDTH  requester 1 operands.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  WIDTH  req_a XOR req_b of the served job.
- rsp_id  output  1  requester index of the served job.
- busy  output  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: req*_ready combinational, high only for the granted requester and only in IDLE. Grant: single valid requester wins; both valid -> requester other than last_grant wins. On handshake edge: latch a, b into shift registers, latch id, clear bit counter and result register, go to RUN, update last_grant.
- RUN: cell inputs = a_sh[0], b_sh[0]; each edge shift a_sh, b_sh right by 1; shift cell output into result MSB (result = {c, result[WIDTH-1:1]}); counter += 1. When counter reaches WIDTH-1 on an edge, go to DONE on that edge. Inputs ignored; ready low.
- DONE: rsp_valid = 1, rsp_data = result, rsp_id = latched id, stable until handshake. On rsp_valid & rsp_ready edge -> IDLE.
- rsp_data/rsp_id hold last value in IDLE; only rsp_valid qualifies them.
- Counter width $clog2(WIDTH)+1 bits; no wrap possible; WIDTH=1 goes IDLE -> RUN -> DONE with one RUN cycle.
- No request queued; requester holds valid until its ready.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_data 0, rsp_id 0, busy 0, req*_ready 0 until first evaluation of grant, last_grant 1 (requester 0 wins first tie).
- Reset mid-RUN or mid-DONE: job discarded, no response, outputs return to reset values asynchronously.
- Latency: accept on edge E0 -> rsp_valid high after edge E0+WIDTH.
- Throughput: minimum WIDTH+2 cycles per job (IDLE accept, WIDTH RUN, one DONE cycle with rsp_ready high).
- rsp_ready held low: stays in DONE indefinitely, requests stall (ready low).
- Request arriving same cycle as DONE handshake: not accepted until next cycle (IDLE).
- Cell path is combinational within one cycle: a_sh[0]/b_sh[0] register -> cell -> result register.

## Structure
- Package bss_pkg: state enum (IDLE, RUN, DONE), req_id_t (1-bit), WIDTH range check helper.
- One sub-module instance: combination_bit for the per-bit evaluation; arbiter, counter, shift registers inline.

## Test plan
- WIDTH=8, req0 a=8'hA5 b=8'h0F, rsp_ready=1 -> rsp_valid 8 cycles after accept, rsp_data=8'hAA, rsp_id=0.
- Both valid from reset, req0 a=8'hFF b=8'h00, req1 a=8'h3C b=8'h3C -> req0 served first (8'hFF, id 0), then req1 (8'h00, id 1); alternation continues under sustained contention.
- rsp_ready low 5 cycles in DONE -> rsp_valid/rsp_data/rsp_id stable, req*_ready low, then single handshake returns to IDLE.
- rst pulsed at counter=3 -> no rsp_valid, busy 0, next job after release returns correct result.
- WIDTH=1, a=1 b=0 -> rsp_data=1 one cycle after accept; a=1 b=1 -> 0.
- Random 1000 jobs, random valids/rsp_ready -> every result equals a^b, id matches, no starvation beyond one job.

Source files
------------

// File: rtl/bss_pkg.sv
// bss_pkg: shared types and helpers for bit_serial_scheduler.
//   state_t  - scheduler FSM states (IDLE, RUN, DONE)
//   req_id_t - requester index (two requesters)
//   width_ok - legal operand width check (1..64)
package bss_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef logic req_id_t;
    function automatic bit width_ok(input int w);
        return w >= 1 && w <= 64;
    endfunction
endpackage

// File: rtl/bit_serial_scheduler_if.sv
// bit_serial_scheduler_if: request/response bundle of bit_serial_scheduler.
//   req0_* / req1_* - valid/ready operand ports of the two requesters (a, b: WIDTH bits)
//   rsp_*           - valid/ready result port (data: WIDTH bits, id: requester index)
//   busy            - scheduler is running or holding a result
//   master drives requests and rsp_ready; slave is the scheduler side.
interface bit_serial_scheduler_if #(parameter int WIDTH = 8);
    import bss_pkg::*;
    logic             req0_valid, req0_ready;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    req_id_t          rsp_id;
    logic             busy;
    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy
    );
    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy
    );
endinterface

// File: rtl/combination_bit.sv
// combination_bit: shared single-bit evaluation cell.
//   a, b - operand bits; c - a XOR b
module combination_bit (
    input  logic a,
    input  logic b,
    output logic c
);
    assign c = a ^ b;
endmodule

// File: rtl/bit_serial_scheduler.sv
// bit_serial_scheduler: round-robin shares one combination_bit cell between two
// requesters, evaluating WIDTH-bit operands LSB first, one bit per clock.
//   clk, rst - rising-edge clock, asynchronous active-high reset
//   bus      - slave side of bit_serial_scheduler_if (requests, response, busy)
module bit_serial_scheduler
    import bss_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                   clk,
    input logic                   rst,
    bit_serial_scheduler_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    if (!width_ok(WIDTH)) begin : g_width_bad
        $error("bit_serial_scheduler: WIDTH must be 1..64");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    req_id_t          id_q, id_d, last_q, last_d;
    logic             grant1, cell_c;

    combination_bit u_cell (.a(a_sh_q[0]), .b(b_sh_q[0]), .c(cell_c));

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign grant1         = bus.req1_valid && (!bus.req0_valid || !last_q);
    assign bus.req0_ready = state_q == IDLE && bus.req0_valid && !grant1;
    assign bus.req1_ready = state_q == IDLE && grant1;
    assign bus.rsp_valid  = state_q == DONE;
    assign bus.rsp_data   = res_q;
    assign bus.rsp_id     = id_q;
    assign bus.busy       = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: if (bus.req0_ready || bus.req1_ready) begin
                state_d = RUN;
                a_sh_d  = grant1 ? bus.req1_a : bus.req0_a;
                b_sh_d  = grant1 ? bus.req1_b : bus.req0_b;
                id_d    = grant1;
                last_d  = grant1;
                cnt_d   = '0;
                res_d   = '0;
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                // New bit enters at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts.
                res_d   = WIDTH'({cell_c, res_q} >> 1);
                cnt_d   = cnt_q + CW'(1);
                state_d = cnt_q == CW'(WIDTH - 1) ? DONE : RUN;
            end
            DONE: state_d = bus.rsp_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_bit_serial_scheduler.sv
// tb_bit_serial_scheduler: scoreboard bench for bit_serial_scheduler (WIDTH=8 and WIDTH=1).
module tb_bit_serial_scheduler;
    typedef struct { logic [7:0] d; logic id; int acc; } exp_t;
    typedef struct { logic [7:0] a; logic [7:0] b; } op_t;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit_serial_scheduler_if #(.WIDTH(8)) if8 ();
    bit_serial_scheduler_if #(.WIDTH(1)) if1 ();
    bit_serial_scheduler #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    bit_serial_scheduler #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    int checks = 0;
    int fails = 0;
    int done_cnt = 0;
    bit rnd = 0;
    logic rr8 = 1;
    logic v[2];
    logic rdy[2];
    logic [7:0] da[2], db[2];
    op_t pend[2][$];
    exp_t exp8[$];
    logic last8 = 1;
    logic prev8 = 0;

    assign if8.req0_valid = v[0];
    assign if8.req0_a = da[0];
    assign if8.req0_b = db[0];
    assign if8.req1_valid = v[1];
    assign if8.req1_a = da[1];
    assign if8.req1_b = db[1];
    assign if8.rsp_ready = rr8;
    assign rdy[0] = if8.req0_ready;
    assign rdy[1] = if8.req1_ready;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    // Each requester presents its queued pairs and holds valid until accepted.
    for (genvar r = 0; r < 2; r++) begin : g_req
        initial begin
            op_t op;
            int n;
            v[r] = 0;
            da[r] = 0;
            db[r] = 0;
            forever begin
                @(posedge clk);
                #1;
                if (rst || pend[r].size() == 0) continue;
                if (rnd && ($urandom % 3 == 0)) continue;
                op = pend[r].pop_front();
                v[r] = 1;
                da[r] = op.a;
                db[r] = op.b;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!rdy[r] && n < 400);
                chk("req_accept", rdy[r], 1);
                @(posedge clk);
                #1;
                v[r] = 0;
            end
        end
    end

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin : mon8
        exp_t e;
        logic got_id, want_id;
        if (rst) begin
            exp8.delete();
            last8 <= 1;
            prev8 <= 0;
        end else begin
            if ((v[0] && rdy[0]) || (v[1] && rdy[1])) begin
                chk("single_grant", rdy[0] && rdy[1], 0);
                got_id = rdy[1];
                want_id = (v[0] && v[1]) ? !last8 : v[1];
                chk("grant_id", got_id, want_id);
                last8 <= got_id;
                exp8.push_back('{d: da[got_id] ^ db[got_id], id: got_id, acc: cyc});
            end
            if (if8.rsp_valid && !prev8) begin
                if (exp8.size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("latency", cyc, exp8[0].acc + 9);
            end
            if (if8.rsp_valid && if8.rsp_ready && exp8.size() > 0) begin
                e = exp8.pop_front();
                chk("rsp_data", if8.rsp_data, e.d);
                chk("rsp_id", if8.rsp_id, e.id);
                done_cnt++;
            end
            prev8 <= if8.rsp_valid;
        end
    end

    task automatic drain(input bit random_rr, input int budget);
        int n = 0;
        while ((pend[0].size() > 0 || pend[1].size() > 0 || v[0] || v[1] || if8.busy || exp8.size() > 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (random_rr) rr8 = ($urandom % 4) != 0;
        end
        rr8 = 1;
        chk("drain", n < budget, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base;
        if1.req0_valid = 0; if1.req0_a = 0; if1.req0_b = 0;
        if1.req1_valid = 0; if1.req1_a = 0; if1.req1_b = 0;
        if1.rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", if8.busy, 0);
        chk("rst_rsp_valid", if8.rsp_valid, 0);
        chk("rst_rsp_data", if8.rsp_data, 0);
        chk("rst_rsp_id", if8.rsp_id, 0);
        chk("rst_ready0", if8.req0_ready, 0);
        chk("rst_ready1", if8.req1_ready, 0);
        @(negedge clk);
        rst = 0;

        // Contention from reset: requester 0 first, then strict alternation.
        pend[0].push_back('{8'hFF, 8'h00});
        pend[1].push_back('{8'h3C, 8'h3C});
        pend[0].push_back('{8'h81, 8'h18});
        pend[1].push_back('{8'hF0, 8'h0F});
        pend[0].push_back('{8'h01, 8'h02});
        pend[1].push_back('{8'h3C, 8'h3C});
        drain(0, 400);
        chk("cont_last_data", if8.rsp_data, 8'h00);
        chk("cont_last_id", if8.rsp_id, 1);
        chk("cont_count", done_cnt, 6);

        pend[0].push_back('{8'hA5, 8'h0F});
        drain(0, 200);
        chk("t1_data", if8.rsp_data, 8'hAA);
        chk("t1_id", if8.rsp_id, 0);

        // Consumer stalls five cycles in DONE while requester 1 waits.
        rr8 = 0;
        pend[0].push_back('{8'h12, 8'h34});
        n = 0;
        while (!if8.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reach_done", if8.rsp_valid, 1);
        pend[1].push_back('{8'h55, 8'h0F});
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", if8.rsp_valid, 1);
            chk("stall_data", if8.rsp_data, 8'h26);
            chk("stall_id", if8.rsp_id, 0);
            chk("stall_ready1", if8.req1_ready, 0);
            chk("stall_busy", if8.busy, 1);
        end
        @(posedge clk);
        #1;
        rr8 = 1;
        @(negedge clk);
        chk("hs_ready1", if8.req1_ready, 0);
        @(negedge clk);
        chk("next_ready1", if8.req1_ready, 1);
        drain(0, 200);
        chk("stall_next_data", if8.rsp_data, 8'h5A);
        chk("stall_next_id", if8.rsp_id, 1);

        // Reset mid-RUN discards the job.
        pend[0].push_back('{8'h5A, 8'hFF});
        n = 0;
        while (!if8.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_job_started", if8.busy, 1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk("midrst_busy", if8.busy, 0);
        chk("midrst_valid", if8.rsp_valid, 0);
        chk("midrst_data", if8.rsp_data, 0);
        chk("midrst_id", if8.rsp_id, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        repeat (12) @(negedge clk);
        chk("midrst_no_rsp", if8.rsp_valid, 0);
        pend[1].push_back('{8'h0F, 8'hF0});
        drain(0, 200);
        chk("postrst_data", if8.rsp_data, 8'hFF);
        chk("postrst_id", if8.rsp_id, 1);

        // WIDTH=1 instance: one RUN cycle.
        @(posedge clk);
        #1;
        if1.req0_valid = 1; if1.req0_a = 1; if1.req0_b = 0;
        @(negedge clk);
        chk("w1_ready0", if1.req0_ready, 1);
        @(posedge clk);
        #1;
        if1.req0_valid = 0;
        @(negedge clk);
        chk("w1_run_valid", if1.rsp_valid, 0);
        chk("w1_run_busy", if1.busy, 1);
        @(negedge clk);
        chk("w1_valid", if1.rsp_valid, 1);
        chk("w1_data", if1.rsp_data, 1);
        chk("w1_id", if1.rsp_id, 0);
        @(posedge clk);
        #1;
        if1.req1_valid = 1; if1.req1_a = 1; if1.req1_b = 1;
        @(negedge clk);
        chk("w1_ready1", if1.req1_ready, 1);
        @(posedge clk);
        #1;
        if1.req1_valid = 0;
        @(negedge clk);
        @(negedge clk);
        chk("w1b_valid", if1.rsp_valid, 1);
        chk("w1b_data", if1.rsp_data, 0);
        chk("w1b_id", if1.rsp_id, 1);

        // Random jobs, random request gaps and random consumer stalls.
        base = done_cnt;
        rnd = 1;
        for (int i = 0; i < 1000; i++) pend[$urandom % 2].push_back('{8'($urandom), 8'($urandom)});
        drain(1, 40000);
        rnd = 0;
        chk("rand_count", done_cnt - base, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
